// File: rtl/serial_full_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// with a registered borrow and a start/done handshake.
module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_shift;

    // One full-subtractor stage on the current LSBs.
    assign d_bit     = sa_q[0] ^ sb_q[0] ^ br_q;
    assign br_next   = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    assign res_shift = {d_bit, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        br_d    = br_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                br_d  = br_next;
                res_d = res_shift;
                cnt_d = cnt_q + CW'(1);
                // Outputs update only on the final bit so partial results stay hidden.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    diff_d  = res_shift;
                    bout_d  = br_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            br_q    <= br_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Directed bench for serial_full_subtractor (WIDTH=8) with immediate assertions
// and a small arithmetic model for the expected results.
module tb_serial_full_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int tests = 0;
    int fails = 0;

    serial_full_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits n busy cycles; flags any done pulse or output change while running.
    task automatic run_phase(input string tag, input int n);
        logic [W-1:0] held_d;
        logic         held_b;
        logic         ok;
        held_d = diff;
        held_b = bout;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (!(busy === 1'b1 && done === 1'b0 && diff === held_d && bout === held_b)) ok = 1'b0;
            @(negedge clk);
        end
        check(tag, {31'b0, ok}, 32'd1);
    endtask

    // Issues start at the current negedge; returns at the negedge of the done cycle.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tbin);
        logic [W:0] m;
        m = {1'b0, ta} - {1'b0, tb} - {{W{1'b0}}, tbin};
        a = ta;
        b = tb;
        bin = tbin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~ta;
        b = ~tb;
        bin = ~tbin;
        run_phase({tag, "_run"}, W);
        check({tag, "_done"}, {30'b0, busy, done}, 32'b01);
        check({tag, "_diff"}, {24'b0, diff}, {24'b0, m[W-1:0]});
        check({tag, "_bout"}, {31'b0, bout}, {31'b0, m[W]});
    endtask

    initial begin
        logic [W:0]   m;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbin;
        logic         ok;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        #2;
        check("reset_outputs", {21'b0, busy, done, diff, bout}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {30'b0, busy, done}, 32'd0);

        run_op("t1_100_37", 8'd100, 8'd37, 1'b0);
        check("t1_diff_const", {24'b0, diff}, 32'd63);
        @(negedge clk);
        check("t1_done_one_cycle", {30'b0, busy, done}, 32'd0);
        check("t1_diff_held", {23'b0, bout, diff}, 32'd63);

        run_op("t2_5_10", 8'd5, 8'd10, 1'b0);
        check("t2_diff_const", {23'b0, bout, diff}, {23'b0, 1'b1, 8'hFB});
        @(negedge clk);
        run_op("t2_0_0_bin", 8'd0, 8'd0, 1'b1);
        check("t2b_diff_const", {23'b0, bout, diff}, {23'b0, 1'b1, 8'hFF});
        @(negedge clk);
        run_op("t2_255_255", 8'd255, 8'd255, 1'b0);
        check("t2c_diff_const", {23'b0, bout, diff}, 32'd0);

        // Back-to-back from DONE: no idle gap, result WIDTH+1 cycles later.
        run_op("t4_b2b", 8'd200, 8'd1, 1'b0);
        check("t4_diff_const", {23'b0, bout, diff}, 32'd199);
        @(negedge clk);

        // start held high through RUN with changing operands.
        a = 8'd100;
        b = 8'd37;
        bin = 1'b0;
        start = 1'b1;
        @(negedge clk);
        a = 8'd50;
        b = 8'd20;
        bin = 1'b1;
        run_phase("t3_run1", W);
        check("t3_first_result", {22'b0, done, bout, diff}, {22'b0, 1'b1, 1'b0, 8'd63});
        @(negedge clk);
        start = 1'b0;
        run_phase("t3_run2", W);
        check("t3_second_result", {22'b0, done, bout, diff}, {22'b0, 1'b1, 1'b0, 8'd29});
        @(negedge clk);

        // Reset mid-RUN after three bits.
        a = 8'd17;
        b = 8'd90;
        bin = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_async_reset", {21'b0, busy, done, diff, bout}, 32'd0);
        ok = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        rst = 1'b0;
        repeat (W + 2) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        check("t5_no_done_after_abort", {31'b0, ok}, 32'd1);
        run_op("t5_fresh", 8'd17, 8'd90, 1'b0);
        check("t5_fresh_const", {23'b0, bout, diff}, {23'b0, 1'b1, 8'd183});
        @(negedge clk);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rbin = 1'($urandom);
            m = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
            a = ra;
            b = rb;
            bin = rbin;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (W) @(negedge clk);
            check("rand_result", {22'b0, done, bout, diff}, {22'b0, 1'b1, m});
            if (i % 2 == 0) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
